// File: rtl/riscv_fetch_stage.sv
// riscv_fetch_stage: instruction-fetch stage and IF/ID pipeline register of the
// pipelined RV32I core. It owns the PC, drives the instruction-memory request
// and handles variable memory latency. A one-entry skid buffer (the HOLD
// state) keeps a word that arrives while ID is stalled. EX-stage redirects
// flush the fetch path.
//
// Optional feature: define FETCH_PERF_EN to build the fetch-wait and flush
// performance counters. Without it, both perf ports read as zero and no
// counter flops exist.
module riscv_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] id_ins_code,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic [31:0] perf_wait_cycles,
  output logic [31:0] perf_flushes
);

  // FETCH: a request is outstanding for pc_q. HOLD: the skid buffer holds the
  // word for pc_q and no request is made.
  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] id_ins_q, id_ins_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
  logic        id_valid_q, id_valid_d;

  logic [31:0] pc_plus4;
  logic [31:0] redirect_target;
  logic        unused_redirect_lsbs;

  // Instructions are word aligned, so the low target bits carry no information.
  assign redirect_target      = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign pc_plus4             = pc_q + 32'd4;

  assign imem_addr   = pc_q;
  assign imem_req    = (state_q == FETCH) && rst_n;
  assign id_ins_code = id_ins_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = id_pc_plus4_q;
  assign id_valid    = id_valid_q;

  // Next-state logic for the PC, the skid buffer and the IF/ID register.
  always_comb begin
    // NOTE: every _d signal gets its hold value first, so any path that skips
    // an assignment keeps the register value instead of inferring a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    skid_d        = skid_q;
    id_ins_d      = id_ins_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    id_valid_d    = id_valid_q;

    unique case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          // The branch in EX is older than anything fetched, so any memory
          // response this cycle is dropped.
          pc_d       = redirect_target;
          id_valid_d = 1'b0;
          id_ins_d   = NOP_INSN;
        end else if (imem_ready && !stall) begin
          id_ins_d      = imem_rdata;
          id_pc_d       = pc_q;
          id_pc_plus4_d = pc_plus4;
          id_valid_d    = 1'b1;
          pc_d          = pc_plus4;
        end else if (imem_ready) begin
          // ID cannot take the word yet. Park it so it is not lost, and stop
          // requesting until it drains.
          skid_d  = imem_rdata;
          state_d = HOLD;
        end else if (!stall) begin
          id_valid_d = 1'b0;
          id_ins_d   = NOP_INSN;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d       = redirect_target;
          id_valid_d = 1'b0;
          id_ins_d   = NOP_INSN;
          state_d    = FETCH;
        end else if (!stall) begin
          // pc_q has not moved since the word was captured, so it is still
          // the address of the skid contents.
          id_ins_d      = skid_q;
          id_pc_d       = pc_q;
          id_pc_plus4_d = pc_plus4;
          id_valid_d    = 1'b1;
          pc_d          = pc_plus4;
          state_d       = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // State, PC, skid and IF/ID registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      pc_q          <= {RESET_PC[31:2], 2'b00};
      // NOTE: the skid data register is reset along with its control, so a
      // reset taken in HOLD can never leave a stale word behind.
      skid_q        <= NOP_INSN;
      id_ins_q      <= NOP_INSN;
      id_pc_q       <= 32'h0000_0000;
      id_pc_plus4_q <= 32'h0000_0004;
      id_valid_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so all
      // flops see the pre-edge values of each other.
      state_q       <= state_d;
      pc_q          <= pc_d;
      skid_q        <= skid_d;
      id_ins_q      <= id_ins_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      id_valid_q    <= id_valid_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_wait_q, perf_wait_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  // Count cycles spent waiting on memory and the number of redirects taken.
  // Both counters wrap.
  always_comb begin
    perf_wait_d  = perf_wait_q;
    perf_flush_d = perf_flush_q;
    if ((state_q == FETCH) && !imem_ready) perf_wait_d = perf_wait_q + 32'd1;
    if (redirect_valid) perf_flush_d = perf_flush_q + 32'd1;
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_wait_q  <= 32'h0;
      perf_flush_q <= 32'h0;
    end else begin
      perf_wait_q  <= perf_wait_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_wait_cycles = perf_wait_q;
  assign perf_flushes     = perf_flush_q;
`else
  assign perf_wait_cycles = 32'h0;
  assign perf_flushes     = 32'h0;
`endif

endmodule

// File: doc/riscv_fetch_stage.md
Name: riscv_fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register of the pipelined RV32I core. Owns the PC and drives the instruction-memory interface. Absorbs variable memory latency, decode-stage stalls and EX-stage branch/jump redirects. Presents a stable 32-bit ins_code, with its PC, to the decode stage (immediate generator, control decoder, register file).

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
NOP_INSN, 32'h0000_0013, bubble instruction (addi x0,x0,0) driven on id_ins_code when id_valid=0.

Ports:
clk  input  1  core clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
stall  input  1  hazard unit: hold IF/ID and PC this cycle
redirect_valid  input  1  EX-stage taken branch/jump; flush and reload PC
redirect_pc  input  32  redirect target; bits [1:0] ignored (forced 0)
imem_req  output  1  fetch request for imem_addr
imem_addr  output  32  fetch address (current PC)
imem_rdata  input  32  instruction word for imem_addr, valid when imem_ready=1
imem_ready  input  1  imem_rdata valid this cycle; may stay low any number of cycles
id_ins_code  output  32  instruction to decode
id_pc  output  32  PC of id_ins_code
id_pc_plus4  output  32  id_pc + 4, wraps mod 2^32
id_valid  output  1  id_ins_code is a real instruction
perf_wait_cycles  output  32  fetch-wait counter (see Optional Feature)
perf_flushes  output  32  redirect counter (see Optional Feature)

Behaviour:
- Reset (async assert, sync release by flop): pc=RESET_PC; state=FETCH; id_valid=0; id_ins_code=NOP_INSN; id_pc=0; id_pc_plus4=4; skid buffer empty; perf counters=0.
- imem_addr = pc, always. imem_req = 1 in FETCH; 0 in HOLD and while rst_n=0.
- Memory contract: imem_addr may change in any cycle. The memory asserts imem_ready only when imem_rdata matches the current imem_addr.
- FETCH, per clock edge, first match wins:
  - redirect_valid=1: pc <= {redirect_pc[31:2],2'b00}. IF/ID <= bubble (id_valid=0, id_ins_code=NOP_INSN). Any imem response this cycle is discarded. Stay in FETCH.
  - imem_ready=1 and stall=0: IF/ID <= {imem_rdata, pc, pc+4, valid=1}; pc <= pc+4.
  - imem_ready=1 and stall=1: skid <= {imem_rdata, pc}. IF/ID and pc hold. Go to HOLD.
  - imem_ready=0 and stall=0: IF/ID <= bubble; pc holds.
  - imem_ready=0 and stall=1: everything holds.
- HOLD (skid full, no request), per clock edge:
  - redirect_valid=1: drop skid; pc <= redirect target; IF/ID <= bubble; go to FETCH.
  - stall=1: hold all.
  - stall=0: IF/ID <= skid contents, valid=1; pc <= pc+4; go to FETCH.
- Redirect beats stall in both states (the branch in EX is older than the instruction stalled in ID).
- Latency: instruction visible on id_* the edge after imem_ready, or the edge stall drops in HOLD. Back-to-back fetch gives 1 instruction/cycle.
- Each fetched word reaches ID exactly once, in order. None is lost or duplicated across stall, redirect or HOLD.
- PC arithmetic is 32-bit unsigned; 32'hFFFF_FFFC + 4 = 0.
- Reset mid-wait or mid-HOLD returns immediately to the reset state; the skid is cleared.

Optional Feature:
Macro FETCH_PERF_EN.
- Defined: perf_wait_cycles increments every cycle with state=FETCH, imem_ready=0 and rst_n=1. perf_flushes increments on every edge where redirect_valid=1. Both wrap at 2^32 and reset to 0.
- Not defined: both ports tie to 32'h0 and no counter flops are built. Port list is unchanged.

Test Plan:
1. Reset release, memory always ready, words 0x00500093, 0x00A00113 at 0x0, 0x4 -> id_pc 0x0 then 0x4; id_ins_code matches; id_valid=1 from cycle 1 after reset.
2. imem_ready low 3 cycles at pc=0x8 -> 3 bubbles (id_valid=0, id_ins_code=0x00000013); then word at 0x8 with id_pc_plus4=0xC; perf_wait_cycles=3 with FETCH_PERF_EN.
3. stall high 2 cycles while imem_ready=1 at pc=0x10 -> id_* frozen; HOLD entered, imem_req=0; on release id_pc=0x10, next fetch 0x14, no duplicate.
4. redirect_valid with redirect_pc=0x103, same cycle as imem_ready and stall=1 -> bubble in ID; imem_addr=0x100 next cycle; the discarded word never appears; perf_flushes=1.
5. pc=0xFFFFFFFC, memory ready -> id_pc_plus4=0x0; next imem_addr=0x0.
6. rst_n pulsed low while in HOLD -> outputs return to reset values immediately; imem_addr=RESET_PC; skid contents never delivered.
